poly_tone_pwm: RTL and testbench

Parametrised polyphonic successor to the single-tone PWM audio generator. It holds NUM_CH independent square-wave tone channels, each with its own period, volume and gate. Channels are programmed through a valid/ready config port, and retunes are applied glitch-free at the channel's period boundary. The block mixes all channels into one PWM bitstream that drives the board audio output stage (open-drain buffering and AUD_SD stay outside this block).

---
 rtl/poly_tone_pwm.sv | 171 +++++++++++++++++
 tb/tb_poly_tone_pwm.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_tone_pwm.sv
// -----------------------------------------------------------------------------
// poly_tone_pwm
//
// Polyphonic square-wave tone generator with a single PWM mixer output.
// NUM_CH independent channels each hold a live configuration (period, volume,
// gate) plus a shadow copy and a pending flag. A config write lands in the
// shadow and is copied to the live registers only when the channel is idle or
// at the end of its current period. A retune or a gate-off therefore never cuts
// a square-wave period short, which keeps the output free of clicks.
//
// Ports
//   clk         system clock
//   resetn      asynchronous active-low reset
//   cfg_valid   config request
//   cfg_ready   channel on cfg_ch has no pending config (combinational)
//   cfg_ch      target channel
//   cfg_period  tone period in clk cycles (0 and 1 keep the channel silent)
//   cfg_vol     channel amplitude, 0 = silent
//   cfg_gate    1 = channel on, 0 = channel off
//   ch_active   per channel: live gate set and live period >= 2
//   out_pwm     registered PWM bitstream of the mixed channel levels
// -----------------------------------------------------------------------------
module poly_tone_pwm #(
    parameter int   NUM_CH   = 4,
    parameter int   PERIOD_W = 32,
    parameter int   VOL_W    = 4,
    localparam int  CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int  SUM_W    = VOL_W + CH_W
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [VOL_W-1:0]    cfg_vol,
    input  logic                cfg_gate,
    output logic [NUM_CH-1:0]   ch_active,
    output logic                out_pwm
);

    // cfg_ch can address more slots than there are channels when NUM_CH is
    // not a power of two; those slots always look ready and writes to them are
    // dropped.
    localparam int NSLOT = 1 << CH_W;

    // Per-channel live, shadow and control state.
    logic [PERIOD_W-1:0] live_period_r [NUM_CH];
    logic [VOL_W-1:0]    live_vol_r    [NUM_CH];
    logic [NUM_CH-1:0]   live_gate_r;
    logic [PERIOD_W-1:0] sh_period_r   [NUM_CH];
    logic [VOL_W-1:0]    sh_vol_r      [NUM_CH];
    logic [NUM_CH-1:0]   sh_gate_r;
    logic [NUM_CH-1:0]   pending_r;
    logic [PERIOD_W-1:0] phase_r       [NUM_CH];
    logic [VOL_W-1:0]    lvl_r         [NUM_CH];

    // Mixer and PWM state.
    logic [SUM_W-1:0]    sum_r;
    logic [SUM_W-1:0]    carrier_r;
    logic [SUM_W-1:0]    duty_q_r;
    logic                out_pwm_r;

    // Per-channel decode.
    logic [NUM_CH-1:0]   active_s;
    logic [NUM_CH-1:0]   wrap_s;
    logic [NUM_CH-1:0]   apply_s;
    logic [NUM_CH-1:0]   load_s;
    logic [NUM_CH-1:0]   sq_s;
    logic [NSLOT-1:0]    pend_pad_s;
    logic [SUM_W-1:0]    mix_s;

    // Ready lookup over the padded slot space so any cfg_ch value is safe.
    always_comb begin
        pend_pad_s              = '0;
        pend_pad_s[NUM_CH-1:0]  = pending_r;
        cfg_ready               = ~pend_pad_s[cfg_ch];
    end

    // Channel activity, period wrap, apply/load strobes and square wave.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            active_s[i] = live_gate_r[i] & (live_period_r[i] >= PERIOD_W'(2));
            wrap_s[i]   = (phase_r[i] == (live_period_r[i] - PERIOD_W'(1)));
            // Idle channels take new config at once; running ones only at wrap.
            apply_s[i]  = pending_r[i] & (~active_s[i] | wrap_s[i]);
            load_s[i]   = cfg_valid & cfg_ready & (cfg_ch == CH_W'(i));
            // Odd periods: high for floor(P/2), low for the rest.
            sq_s[i]     = (phase_r[i] < (live_period_r[i] >> 1));
        end
    end

    assign ch_active = active_s;

    // Unsigned sum of the registered channel levels; width always suffices.
    always_comb begin
        mix_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            mix_s = mix_s + SUM_W'(lvl_r[i]);
        end
    end

    // Per-channel config registers, phase counter and registered level.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            live_gate_r <= '0;
            sh_gate_r   <= '0;
            pending_r   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                live_period_r[i] <= '0;
                live_vol_r[i]    <= '0;
                sh_period_r[i]   <= '0;
                sh_vol_r[i]      <= '0;
                phase_r[i]       <= '0;
                lvl_r[i]         <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                // load and apply are exclusive: load needs pending clear,
                // apply needs it set.
                if (load_s[i]) begin
                    sh_period_r[i] <= cfg_period;
                    sh_vol_r[i]    <= cfg_vol;
                    sh_gate_r[i]   <= cfg_gate;
                    pending_r[i]   <= 1'b1;
                end else if (apply_s[i]) begin
                    live_period_r[i] <= sh_period_r[i];
                    live_vol_r[i]    <= sh_vol_r[i];
                    live_gate_r[i]   <= sh_gate_r[i];
                    pending_r[i]     <= 1'b0;
                end else begin
                    pending_r[i]     <= pending_r[i];
                end

                // Phase restarts at 0 with the new config; held at 0 when idle.
                if (apply_s[i]) begin
                    phase_r[i] <= '0;
                end else if (active_s[i] && !wrap_s[i]) begin
                    phase_r[i] <= phase_r[i] + PERIOD_W'(1);
                end else begin
                    phase_r[i] <= '0;
                end

                lvl_r[i] <= (active_s[i] & sq_s[i]) ? live_vol_r[i] : '0;
            end
        end
    end

    // Mix sum, free-running carrier, frame-latched duty and PWM compare.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sum_r     <= '0;
            carrier_r <= '0;
            duty_q_r  <= '0;
            out_pwm_r <= 1'b0;
        end else begin
            sum_r     <= mix_s;
            carrier_r <= carrier_r + SUM_W'(1);
            // Duty only changes at frame start so each frame is a clean pulse.
            if (carrier_r == '0) begin
                duty_q_r <= sum_r;
            end else begin
                duty_q_r <= duty_q_r;
            end
            out_pwm_r <= (carrier_r < duty_q_r);
        end
    end

    assign out_pwm = out_pwm_r;

endmodule

// File: tb/tb_poly_tone_pwm.sv
// -----------------------------------------------------------------------------
// Testbench for poly_tone_pwm (NUM_CH=2, VOL_W=4, SUM_W=5).
// A behavioural model derives each channel's phase from the cycle count since
// the config took effect, and carries the level/sum/duty/output pipeline as
// plain integers. DUT outputs are compared every falling edge; directed
// sections add timing checks for retune, gate-off, illegal periods and reset.
// -----------------------------------------------------------------------------
module tb_poly_tone_pwm;

    localparam int NUM_CH   = 2;
    localparam int PERIOD_W = 16;
    localparam int VOL_W    = 4;
    localparam int CH_W     = 1;
    localparam int SUM_W    = 5;
    localparam int FRAME    = 1 << SUM_W;

    logic                clk = 1'b0;
    logic                resetn = 1'b0;
    logic                cfg_valid = 1'b0;
    logic                cfg_ready;
    logic [CH_W-1:0]     cfg_ch = '0;
    logic [PERIOD_W-1:0] cfg_period = '0;
    logic [VOL_W-1:0]    cfg_vol = '0;
    logic                cfg_gate = 1'b0;
    logic [NUM_CH-1:0]   ch_active;
    logic                out_pwm;

    int checks = 0;
    int errors = 0;

    // Model state: live/shadow config, pending, segment start cycle.
    int m_per   [NUM_CH];
    int m_vol   [NUM_CH];
    int m_gate  [NUM_CH];
    int m_start [NUM_CH];
    int m_pend  [NUM_CH];
    int m_sp    [NUM_CH];
    int m_sv    [NUM_CH];
    int m_sg    [NUM_CH];
    int m_n, m_lvl, m_sum, m_duty, m_out, m_hs_last;

    poly_tone_pwm #(
        .NUM_CH   (NUM_CH),
        .PERIOD_W (PERIOD_W),
        .VOL_W    (VOL_W)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_vol    (cfg_vol),
        .cfg_gate   (cfg_gate),
        .ch_active  (ch_active),
        .out_pwm    (out_pwm)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_act(input int c);
        return (m_gate[c] != 0) && (m_per[c] >= 2);
    endfunction

    function automatic int m_phase(input int c);
        return m_act(c) ? ((m_n - m_start[c]) % m_per[c]) : 0;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_per[c] = 0; m_vol[c] = 0; m_gate[c] = 0; m_start[c] = 0;
            m_pend[c] = 0; m_sp[c] = 0; m_sv[c] = 0; m_sg[c] = 0;
        end
        m_n = 0; m_lvl = 0; m_sum = 0; m_duty = 0; m_out = 0; m_hs_last = 0;
    endtask

    // Advance the model across one rising edge using the pre-edge state.
    task automatic model_step();
        int raw;
        int ph;
        int carrier;
        int c;
        bit hs;
        bit ap [NUM_CH];
        raw = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            ph = m_phase(k);
            if (m_act(k) && (ph < m_per[k] / 2)) raw += m_vol[k];
            ap[k] = (m_pend[k] != 0) && (!m_act(k) || (ph == m_per[k] - 1));
        end
        c  = int'(cfg_ch);
        hs = cfg_valid && (m_pend[c] == 0);
        carrier = m_n % FRAME;
        m_out = (carrier < m_duty) ? 1 : 0;
        if (carrier == 0) m_duty = m_sum;
        m_sum = m_lvl;
        m_lvl = raw;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ap[k]) begin
                m_per[k] = m_sp[k]; m_vol[k] = m_sv[k]; m_gate[k] = m_sg[k];
                m_pend[k] = 0; m_start[k] = m_n + 1;
            end
        end
        if (hs) begin
            m_sp[c] = int'(cfg_period); m_sv[c] = int'(cfg_vol); m_sg[c] = int'(cfg_gate);
            m_pend[c] = 1;
        end
        m_hs_last = hs ? 1 : 0;
        m_n++;
    endtask

    // One clock: model follows the edge, DUT is compared on the falling edge.
    task automatic tick();
        logic [NUM_CH-1:0] exp_act;
        @(posedge clk);
        model_step();
        @(negedge clk);
        for (int c = 0; c < NUM_CH; c++) exp_act[c] = m_act(c);
        check_val("out_pwm", out_pwm, m_out);
        check_val("ch_active", ch_active, exp_act);
        check_val("cfg_ready", cfg_ready, (m_pend[int'(cfg_ch)] == 0));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic cfg_write(input int ch, input int per, input int vol, input int gate, output int waited);
        cfg_ch = CH_W'(ch); cfg_period = PERIOD_W'(per); cfg_vol = VOL_W'(vol);
        cfg_gate = gate[0]; cfg_valid = 1'b1;
        waited = 0;
        for (int k = 0; k < 2000; k++) begin
            tick();
            waited++;
            if (m_hs_last != 0) break;
        end
        cfg_valid = 1'b0;
        check_val("cfg_accept", m_hs_last, 1);
    endtask

    task automatic wait_ready(input int ch, output int n);
        cfg_ch = CH_W'(ch); cfg_valid = 1'b0;
        n = 0;
        for (int k = 0; k < 3000; k++) begin
            tick();
            n++;
            if (cfg_ready) break;
        end
        check_val("ready_timeout", cfg_ready, 1'b1);
    endtask

    task automatic wait_phase(input int ch, input int target);
        bit hit;
        hit = (m_phase(ch) == target);
        for (int k = 0; k < 2000 && !hit; k++) begin
            tick();
            hit = (m_phase(ch) == target);
        end
        check_val("phase_timeout", hit, 1'b1);
    endtask

    // Asynchronous reset between edges: outputs must clear without a clock.
    task automatic do_reset();
        cfg_valid = 1'b0;
        #2 resetn = 1'b0;
        #1;
        check_val("rst_out_pwm", out_pwm, 1'b0);
        check_val("rst_ch_active", ch_active, '0);
        check_val("rst_cfg_ready", cfg_ready, 1'b1);
        check_val("rst_duty_q", dut.duty_q_r, '0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        int w;
        int ones;
        model_reset();
        #1;
        check_val("init_out_pwm", out_pwm, 1'b0);
        check_val("init_ch_active", ch_active, '0);
        check_val("init_cfg_ready", cfg_ready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        run(4);

        // Single tone: 15/32 for four frames, silent for four.
        cfg_write(0, 256, 15, 1, w);
        tick();
        check_val("single_active", ch_active, 2'b01);
        run(300);
        ones = 0;
        for (int k = 0; k < 256; k++) begin
            tick();
            ones += int'(out_pwm);
        end
        check_val("single_ones", ones, 60);

        // Two channels programmed back to back from idle.
        do_reset();
        cfg_write(0, 256, 15, 1, w);
        cfg_write(1, 256, 15, 1, w);
        run(600);

        // Glitch-free retune at phase 10; ch1 must not stall meanwhile.
        wait_phase(0, 10);
        cfg_write(0, 100, 15, 1, w);
        check_val("retune_accept", w, 1);
        cfg_write(1, 200, 7, 1, w);
        check_val("ch1_no_stall", w, 1);
        wait_ready(0, w);
        check_val("retune_wait", w, 244);
        cfg_write(0, 100, 15, 1, w);
        wait_ready(0, w);
        check_val("new_period", w, 99);

        // Illegal periods on ch1.
        cfg_write(1, 1, 15, 1, w);
        wait_ready(1, w);
        run(3);
        check_val("per1_inactive", ch_active[1], 1'b0);
        cfg_write(1, 0, 15, 1, w);
        wait_ready(1, w);
        run(3);
        check_val("per0_inactive", ch_active[1], 1'b0);

        // Gate off at phase 50 of 256.
        cfg_write(0, 256, 15, 1, w);
        wait_ready(0, w);
        wait_phase(0, 50);
        cfg_write(0, 256, 15, 0, w);
        wait_ready(0, w);
        check_val("gate_off_wait", w, 205);
        check_val("gate_off_active", ch_active[0], 1'b0);
        run(34);
        check_val("gate_off_duty", dut.duty_q_r, '0);

        // Reset mid-run with ch0 active.
        cfg_write(0, 64, 9, 1, w);
        run(100);
        check_val("pre_rst_active", ch_active[0], 1'b1);
        do_reset();
        run(4);

        // Randomized configuration traffic with one mid-run reset.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            cfg_valid  = ($urandom_range(0, 2) == 0);
            cfg_ch     = CH_W'($urandom_range(0, NUM_CH - 1));
            cfg_period = ($urandom_range(0, 7) == 0) ? PERIOD_W'($urandom_range(13, 300))
                                                      : PERIOD_W'($urandom_range(0, 12));
            cfg_vol    = VOL_W'($urandom);
            cfg_gate   = ($urandom_range(0, 3) != 0);
            tick();
        end
        cfg_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
